decoder: RTL and testbench

Instruction sequencing and decode stage of the dcpu core, directly downstream of `fetcher`. It owns the program counter and requests each instruction through a one-cycle fetch pulse. It waits for the 48-bit instruction, splits it into fields and evaluates the condition code against the ALU flags. Instructions that pass are issued to the execute stage through a valid/ready handshake; the block then waits for execute to finish and folds in any branch before fetching again.

---
 rtl/dcpu_pkg.sv | 67 ++++++
 rtl/dcpu_cond.sv | 30 +++
 rtl/decoder.sv | 217 +++++++++++++++++++++
 tb/tb_decoder.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_pkg.sv
// dcpu_pkg: shared definitions for the dcpu core.
//   - addressing-mode and condition-code encodings
//   - bit positions of the 48-bit instruction fields
//   - flag indices into the {N,C,Z} flag vector
//   - decoder state enumeration
//   - instr_len(): instruction length in bytes for a legal addressing mode
package dcpu_pkg;

   // Addressing modes (amode field). Any mode with bit 2 set is illegal.
   localparam logic [2:0] AMODE16     = 3'b000;
   localparam logic [2:0] AMODE32     = 3'b001;
   localparam logic [2:0] AMODE48     = 3'b010;
   localparam logic [2:0] AMODE_IMM32 = 3'b011;

   // Condition codes (cc field).
   localparam logic [2:0] CC_ALWAYS = 3'b000;
   localparam logic [2:0] CC_Z      = 3'b001;
   localparam logic [2:0] CC_NZ     = 3'b010;
   localparam logic [2:0] CC_C      = 3'b011;
   localparam logic [2:0] CC_NC     = 3'b100;
   localparam logic [2:0] CC_N      = 3'b101;
   localparam logic [2:0] CC_NN     = 3'b110;
   localparam logic [2:0] CC_NEVER  = 3'b111;

   // Instruction field bit positions.
   localparam int OP_MSB    = 47;
   localparam int OP_LSB    = 43;
   localparam int CC_MSB    = 42;
   localparam int CC_LSB    = 40;
   localparam int RA_MSB    = 39;
   localparam int RA_LSB    = 36;
   localparam int AMODE_MSB = 35;
   localparam int AMODE_LSB = 33;
   localparam int IGN_BIT   = 32;
   localparam int RB_MSB    = 31;
   localparam int RB_LSB    = 28;
   localparam int IMM12_MSB = 27;
   localparam int IMM12_LSB = 16;

   // Index of each flag inside the {N,C,Z} vector.
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_DECODE = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_EXEC   = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // Byte length of an instruction; only meaningful for legal modes.
   function automatic logic [31:0] instr_len(input logic [2:0] amode);
      logic [31:0] len;
      case (amode)
         AMODE16: len = 32'd2;
         AMODE32: len = 32'd4;
         AMODE48: len = 32'd6;
         AMODE_IMM32: len = 32'd6;
         default: len = 32'd2;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/dcpu_cond.sv
// dcpu_cond: condition-code evaluator (combinational).
//   cc_i    in  3  condition code
//   flags_i in  3  {N,C,Z}
//   pass_o  out 1  1 when the condition holds
// Shared by the decoder and by execute for conditional writes.
module dcpu_cond
   import dcpu_pkg::*;
(
   input  logic [2:0] cc_i,
   input  logic [2:0] flags_i,
   output logic       pass_o
);

   // Select the flag test named by the condition code.
   always_comb begin
      pass_o = 1'b0;
      case (cc_i)
         CC_ALWAYS: pass_o = 1'b1;
         CC_Z:      pass_o = flags_i[FLAG_Z];
         CC_NZ:     pass_o = ~flags_i[FLAG_Z];
         CC_C:      pass_o = flags_i[FLAG_C];
         CC_NC:     pass_o = ~flags_i[FLAG_C];
         CC_N:      pass_o = flags_i[FLAG_N];
         CC_NN:     pass_o = ~flags_i[FLAG_N];
         CC_NEVER:  pass_o = 1'b0;
         default:   pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/decoder.sv
// decoder: instruction sequencing and decode stage of the dcpu core.
//   i_clk, i_reset              clock, synchronous active-high reset
//   o_fetch, o_pc               one-cycle fetch request and its byte address
//   i_instruction, i_done       48-bit instruction and its valid strobe
//   i_flags                     {N,C,Z} from execute
//   o_valid, i_ready            issue handshake towards execute
//   o_op/o_ra/o_rb/o_amode/o_imm/o_pc_next  decoded fields, held while issued
//   i_exec_done, i_branch, i_branch_pc      completion and branch redirect
//   o_illegal                   sticky illegal-instruction flag (core halts)
// One instruction is in flight at a time: fetch, wait, decode, issue,
// wait for execute, then update the PC and fetch again.
module decoder
   import dcpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_fetch,
   output logic [31:0] o_pc,
   input  logic [47:0] i_instruction,
   input  logic        i_done,
   input  logic [2:0]  i_flags,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [4:0]  o_op,
   output logic [3:0]  o_ra,
   output logic [3:0]  o_rb,
   output logic [2:0]  o_amode,
   output logic [31:0] o_imm,
   output logic [31:0] o_pc_next,
   input  logic        i_exec_done,
   input  logic        i_branch,
   input  logic [31:0] i_branch_pc,
   output logic        o_illegal
);

   state_e      state_q,   state_d;
   logic [31:0] pc_q,      pc_d;
   logic [47:0] instr_q,   instr_d;
   logic        valid_q,   valid_d;
   logic        illegal_q, illegal_d;
   logic [4:0]  op_q,      op_d;
   logic [3:0]  ra_q,      ra_d;
   logic [3:0]  rb_q,      rb_d;
   logic [2:0]  amode_q,   amode_d;
   logic [31:0] imm_q,     imm_d;
   logic [31:0] pc_next_q, pc_next_d;

   // Fields of the latched instruction.
   logic [4:0]  op_s;
   logic [2:0]  cc_s;
   logic [3:0]  ra_s;
   logic [2:0]  amode_s;
   logic [3:0]  rb_s;
   logic [31:0] imm_s;
   logic [31:0] len_s;
   logic        legal_s;
   logic        pass_s;
   logic        unused_ign_s;

   assign op_s    = instr_q[OP_MSB:OP_LSB];
   assign cc_s    = instr_q[CC_MSB:CC_LSB];
   assign ra_s    = instr_q[RA_MSB:RA_LSB];
   assign amode_s = instr_q[AMODE_MSB:AMODE_LSB];
   assign len_s   = instr_len(amode_s);
   assign legal_s = ~amode_s[2];
   // Bit 32 carries no meaning in any addressing mode.
   assign unused_ign_s = instr_q[IGN_BIT];

   dcpu_cond u_cond (
      .cc_i    (cc_s),
      .flags_i (i_flags),
      .pass_o  (pass_s)
   );

   // Rb and the immediate depend on the addressing mode; modes without them read 0.
   always_comb begin
      rb_s  = 4'd0;
      imm_s = 32'd0;
      case (amode_s)
         AMODE32: begin
            rb_s  = instr_q[RB_MSB:RB_LSB];
            imm_s = {{20{instr_q[IMM12_MSB]}}, instr_q[IMM12_MSB:IMM12_LSB]};
         end
         AMODE48: begin
            // imm28 is the imm12 slot followed by the trailing 16 bits.
            rb_s  = instr_q[RB_MSB:RB_LSB];
            imm_s = {{4{instr_q[IMM12_MSB]}}, instr_q[IMM12_MSB:0]};
         end
         AMODE_IMM32: begin
            rb_s  = 4'd0;
            imm_s = instr_q[31:0];
         end
         default: begin
            rb_s  = 4'd0;
            imm_s = 32'd0;
         end
      endcase
   end

   // Sequencing FSM next-state and register updates.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      op_d      = op_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      amode_d   = amode_q;
      imm_d     = imm_q;
      pc_next_d = pc_next_q;
      case (state_q)
         ST_FETCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_done) begin
               instr_d = i_instruction;
               state_d = ST_DECODE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DECODE: begin
            if (!legal_s) begin
               illegal_d = 1'b1;
               state_d   = ST_HALT;
            end else if (!pass_s) begin
               // Skipped instruction: advance past it without issuing.
               pc_d    = pc_q + len_s;
               state_d = ST_FETCH;
            end else begin
               op_d      = op_s;
               ra_d      = ra_s;
               rb_d      = rb_s;
               amode_d   = amode_s;
               imm_d     = imm_s;
               pc_next_d = pc_q + len_s;
               valid_d   = 1'b1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_EXEC: begin
            if (i_exec_done) begin
               // pc_next_q already holds pc + len for the issued instruction.
               pc_d    = i_branch ? i_branch_pc : pc_next_q;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            // Unreachable encoding: stop the core rather than run wild.
            illegal_d = 1'b1;
            valid_d   = 1'b0;
            state_d   = ST_HALT;
         end
      endcase
   end

   // State and output registers; reset wins over any pending strobe.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= 48'd0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         op_q      <= 5'd0;
         ra_q      <= 4'd0;
         rb_q      <= 4'd0;
         amode_q   <= 3'd0;
         imm_q     <= 32'd0;
         pc_next_q <= RESET_PC;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         op_q      <= op_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         amode_q   <= amode_d;
         imm_q     <= imm_d;
         pc_next_q <= pc_next_d;
      end
   end

   // The fetch pulse is the FETCH state itself, masked while reset is held
   // so the request never appears before reset is released.
   assign o_fetch   = (state_q == ST_FETCH) & ~i_reset;
   assign o_pc      = pc_q;
   assign o_valid   = valid_q;
   assign o_op      = op_q;
   assign o_ra      = ra_q;
   assign o_rb      = rb_q;
   assign o_amode   = amode_q;
   assign o_imm     = imm_q;
   assign o_pc_next = pc_next_q;
   assign o_illegal = illegal_q;

endmodule

// File: tb/tb_decoder.sv
module tb_decoder;

   logic        i_clk;
   logic        i_reset;
   logic        o_fetch;
   logic [31:0] o_pc;
   logic [47:0] i_instruction;
   logic        i_done;
   logic [2:0]  i_flags;
   logic        o_valid;
   logic        i_ready;
   logic [4:0]  o_op;
   logic [3:0]  o_ra;
   logic [3:0]  o_rb;
   logic [2:0]  o_amode;
   logic [31:0] o_imm;
   logic [31:0] o_pc_next;
   logic        i_exec_done;
   logic        i_branch;
   logic [31:0] i_branch_pc;
   logic        o_illegal;

   int          checks;
   int          failures;
   logic [31:0] exp_pc;

   decoder #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .o_fetch       (o_fetch),
      .o_pc          (o_pc),
      .i_instruction (i_instruction),
      .i_done        (i_done),
      .i_flags       (i_flags),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_op          (o_op),
      .o_ra          (o_ra),
      .o_rb          (o_rb),
      .o_amode       (o_amode),
      .o_imm         (o_imm),
      .o_pc_next     (o_pc_next),
      .i_exec_done   (i_exec_done),
      .i_branch      (i_branch),
      .i_branch_pc   (i_branch_pc),
      .o_illegal     (o_illegal)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_len(input logic [47:0] ins);
      int am;
      am = int'((ins >> 33) & 48'd7);
      if (am == 0) return 32'd2;
      else if (am == 1) return 32'd4;
      else return 32'd6;
   endfunction

   function automatic logic [31:0] m_imm(input logic [47:0] ins);
      longint v;
      int     am;
      am = int'((ins >> 33) & 48'd7);
      v  = 64'sd0;
      if (am == 1) begin
         v = longint'((ins >> 16) & 48'hFFF);
         if (v >= 64'sd2048) v = v - 64'sd4096;
      end else if (am == 2) begin
         v = longint'(ins & 48'h0FFF_FFFF);
         if (v >= 64'sd134217728) v = v - 64'sd268435456;
      end else if (am == 3) begin
         v = longint'(ins & 48'hFFFF_FFFF);
      end
      return v[31:0];
   endfunction

   function automatic logic [3:0] m_rb(input logic [47:0] ins);
      int am;
      am = int'((ins >> 33) & 48'd7);
      if (am == 1 || am == 2) return 4'((ins >> 28) & 48'hF);
      else return 4'd0;
   endfunction

   function automatic bit m_pass(input logic [2:0] cc, input logic [2:0] flags);
      bit n, c, z;
      n = flags[2]; c = flags[1]; z = flags[0];
      case (cc)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return c;
         3'd4: return !c;
         3'd5: return n;
         3'd6: return !n;
         default: return 1'b0;
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick;
      @(negedge i_clk);
   endtask

   // Leaves the bench in the first cycle after reset release (the fetch cycle).
   task automatic apply_reset;
      i_reset = 1'b1; i_done = 1'b0; i_ready = 1'b0;
      i_exec_done = 1'b0; i_branch = 1'b0; i_branch_pc = 32'd0;
      i_instruction = 48'd0; i_flags = 3'd0;
      tick; tick;
      i_reset = 1'b0;
      #1;
      exp_pc = 32'h0000_0000;
   endtask

   // One full instruction starting in a fetch cycle; checks timing and fields.
   task automatic do_instr(input logic [47:0] ins, input logic [2:0] flags,
                           input int wdelay, input int rdelay, input int edelay,
                           input bit br, input logic [31:0] bpc);
      bit          pass;
      bit          ok;
      logic [31:0] len;
      logic [4:0]  e_op;
      logic [3:0]  e_ra;
      logic [3:0]  e_rb;
      logic [2:0]  e_am;
      logic [31:0] e_imm;
      logic [31:0] e_next;
      pass   = m_pass(3'((ins >> 40) & 48'd7), flags);
      len    = m_len(ins);
      e_op   = 5'((ins >> 43) & 48'h1F);
      e_ra   = 4'((ins >> 36) & 48'hF);
      e_am   = 3'((ins >> 33) & 48'd7);
      e_rb   = m_rb(ins);
      e_imm  = m_imm(ins);
      e_next = exp_pc + len;

      checks++;
      if (o_fetch !== 1'b1 || o_pc !== exp_pc) begin
         failures++;
         $display("FAIL fetch_start: o_fetch=%b o_pc=%h, expected 1 and %h", o_fetch, o_pc, exp_pc);
      end
      i_flags = flags;
      tick;
      for (int k = 0; k < wdelay; k++) begin
         i_instruction = {16'($urandom), $urandom};
         checks++;
         if (o_fetch !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: o_fetch=%b o_valid=%b, expected 0 0", o_fetch, o_valid);
         end
         tick;
      end
      i_instruction = ins;
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
      i_instruction = {16'($urandom), $urandom};
      checks++;
      if (o_valid !== 1'b0 || o_fetch !== 1'b0) begin
         failures++;
         $display("FAIL decode_cycle: o_valid=%b o_fetch=%b, expected 0 0", o_valid, o_fetch);
      end
      tick;
      if (!pass) begin
         checks++;
         if (o_valid !== 1'b0 || o_fetch !== 1'b1 || o_pc !== e_next) begin
            failures++;
            $display("FAIL cc_skip: o_valid=%b o_fetch=%b o_pc=%h, expected 0 1 %h", o_valid, o_fetch, o_pc, e_next);
         end
         exp_pc = e_next;
         return;
      end
      ok = (o_valid === 1'b1 && o_op === e_op && o_ra === e_ra && o_rb === e_rb &&
            o_amode === e_am && o_imm === e_imm && o_pc_next === e_next);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL issue_fields: v=%b op=%h ra=%h rb=%h am=%h imm=%h nx=%h, expected 1 %h %h %h %h %h %h",
                  o_valid, o_op, o_ra, o_rb, o_amode, o_imm, o_pc_next, e_op, e_ra, e_rb, e_am, e_imm, e_next);
      end
      for (int k = 0; k < rdelay; k++) begin
         i_ready = 1'b0;
         tick;
         ok = (o_valid === 1'b1 && o_op === e_op && o_ra === e_ra && o_rb === e_rb &&
               o_amode === e_am && o_imm === e_imm && o_pc_next === e_next);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL issue_hold: v=%b op=%h imm=%h nx=%h, expected 1 %h %h %h",
                     o_valid, o_op, o_imm, o_pc_next, e_op, e_imm, e_next);
         end
      end
      i_ready = 1'b1;
      tick;
      i_ready = 1'b0;
      checks++;
      if (o_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_drop: o_valid=%b, expected 0", o_valid);
      end
      for (int k = 0; k < edelay; k++) begin
         // A branch without exec_done must be ignored.
         i_branch = 1'($urandom);
         i_branch_pc = $urandom;
         tick;
         checks++;
         if (o_fetch !== 1'b0 || o_pc !== exp_pc || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL exec_wait: o_fetch=%b o_pc=%h o_valid=%b, expected 0 %h 0", o_fetch, o_pc, o_valid, exp_pc);
         end
      end
      i_exec_done = 1'b1;
      i_branch = br;
      i_branch_pc = bpc;
      tick;
      i_exec_done = 1'b0;
      i_branch = 1'b0;
      i_branch_pc = 32'd0;
      exp_pc = br ? bpc : e_next;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      i_reset = 1'b1; i_done = 1'b0; i_ready = 1'b0;
      i_exec_done = 1'b0; i_branch = 1'b0; i_branch_pc = 32'd0;
      i_instruction = 48'd0; i_flags = 3'd0;
      tick; tick;
      checks++;
      if (o_fetch !== 1'b0 || o_valid !== 1'b0 || o_illegal !== 1'b0 || o_pc !== 32'd0 ||
          o_op !== 5'd0 || o_ra !== 4'd0 || o_rb !== 4'd0 || o_amode !== 3'd0 ||
          o_imm !== 32'd0 || o_pc_next !== 32'd0) begin
         failures++;
         $display("FAIL reset_values: f=%b v=%b ill=%b pc=%h op=%h imm=%h nx=%h, expected all 0",
                  o_fetch, o_valid, o_illegal, o_pc, o_op, o_imm, o_pc_next);
      end
      i_reset = 1'b0;
      #1;
      checks++;
      if (o_fetch !== 1'b1 || o_pc !== 32'd0) begin
         failures++;
         $display("FAIL first_fetch: o_fetch=%b o_pc=%h, expected 1 00000000", o_fetch, o_pc);
      end
      for (int k = 0; k < 6; k++) begin
         tick;
         checks++;
         if (o_fetch !== 1'b0) begin
            failures++;
            $display("FAIL single_fetch: o_fetch=%b in idle cycle %0d, expected 0", o_fetch, k);
         end
      end
   endtask

   task automatic test_basic;
      apply_reset;
      do_instr(48'h0000_0000_0000, 3'd0, 0, 0, 0, 1'b1, 32'h0000_0100);
      do_instr(48'h1852_2FFF_0000, 3'd0, 1, 0, 1, 1'b0, 32'd0);
      checks++;
      if (o_op !== 5'd3 || o_ra !== 4'd5 || o_rb !== 4'd2 || o_imm !== 32'hFFFF_FFFF ||
          o_pc_next !== 32'h0000_0104 || o_pc !== 32'h0000_0104 || o_fetch !== 1'b1) begin
         failures++;
         $display("FAIL basic_vector: op=%h ra=%h rb=%h imm=%h nx=%h pc=%h f=%b, expected 3 5 2 ffffffff 104 104 1",
                  o_op, o_ra, o_rb, o_imm, o_pc_next, o_pc, o_fetch);
      end
   endtask

   task automatic test_hold;
      do_instr(48'h1856_DEAD_BEEF, 3'd0, 0, 3, 2, 1'b0, 32'd0);
      checks++;
      if (o_imm !== 32'hDEAD_BEEF || o_rb !== 4'd0 || o_pc !== 32'h0000_010A) begin
         failures++;
         $display("FAIL hold_vector: imm=%h rb=%h pc=%h, expected deadbeef 0 0000010a", o_imm, o_rb, o_pc);
      end
   endtask

   task automatic test_cond;
      apply_reset;
      do_instr(48'h0000_0000_0000, 3'd0, 0, 0, 0, 1'b1, 32'h0000_0100);
      do_instr(48'h1950_0000_0000, 3'b000, 0, 0, 0, 1'b0, 32'd0);
      checks++;
      if (o_pc !== 32'h0000_0102 || o_fetch !== 1'b1 || o_valid !== 1'b0) begin
         failures++;
         $display("FAIL cond_false: pc=%h f=%b v=%b, expected 00000102 1 0", o_pc, o_fetch, o_valid);
      end
      do_instr(48'h1950_0000_0000, 3'b001, 0, 1, 0, 1'b0, 32'd0);
      checks++;
      if (o_pc !== 32'h0000_0104 || o_op !== 5'd3 || o_amode !== 3'd0 || o_imm !== 32'd0) begin
         failures++;
         $display("FAIL cond_true: pc=%h op=%h am=%h imm=%h, expected 00000104 3 0 0", o_pc, o_op, o_amode, o_imm);
      end
   endtask

   task automatic test_branch;
      do_instr(48'h0000_0000_0000, 3'd0, 0, 0, 3, 1'b1, 32'h0000_2000);
      checks++;
      if (o_pc !== 32'h0000_2000 || o_fetch !== 1'b1) begin
         failures++;
         $display("FAIL branch_target: pc=%h f=%b, expected 00002000 1", o_pc, o_fetch);
      end
      // PC wrap at the top of the address space.
      do_instr(48'h0000_0000_0000, 3'd0, 0, 0, 0, 1'b1, 32'hFFFF_FFFE);
      do_instr(48'h0000_0000_0000, 3'd0, 0, 0, 0, 1'b0, 32'd0);
      checks++;
      if (o_pc !== 32'h0000_0000 || o_pc_next !== 32'h0000_0000) begin
         failures++;
         $display("FAIL pc_wrap: pc=%h nx=%h, expected 00000000 00000000", o_pc, o_pc_next);
      end
   endtask

   task automatic test_illegal;
      apply_reset;
      tick;
      i_instruction = 48'h1858_0000_0000;
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
      tick;
      checks++;
      if (o_illegal !== 1'b1 || o_valid !== 1'b0) begin
         failures++;
         $display("FAIL illegal_set: ill=%b v=%b, expected 1 0", o_illegal, o_valid);
      end
      for (int k = 0; k < 8; k++) begin
         i_done = 1'($urandom);
         i_exec_done = 1'($urandom);
         i_instruction = 48'h0000_0000_0000;
         tick;
         checks++;
         if (o_fetch !== 1'b0 || o_illegal !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_absorb: f=%b ill=%b v=%b, expected 0 1 0", o_fetch, o_illegal, o_valid);
         end
      end
      i_done = 1'b0;
      i_exec_done = 1'b0;
      i_reset = 1'b1;
      tick;
      checks++;
      if (o_illegal !== 1'b0) begin
         failures++;
         $display("FAIL illegal_clear: ill=%b, expected 0", o_illegal);
      end
      i_reset = 1'b0;
      #1;
      checks++;
      if (o_fetch !== 1'b1 || o_pc !== 32'd0) begin
         failures++;
         $display("FAIL restart_fetch: f=%b pc=%h, expected 1 00000000", o_fetch, o_pc);
      end
   endtask

   task automatic test_reset_mid;
      apply_reset;
      do_instr(48'h0000_0000_0000, 3'd0, 0, 0, 0, 1'b1, 32'h0000_0300);
      tick;
      i_instruction = 48'h1852_2FFF_0000;
      i_done = 1'b1;
      tick;
      i_done = 1'b0;
      tick;
      checks++;
      if (o_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_pre: o_valid=%b, expected 1", o_valid);
      end
      i_ready = 1'b0;
      i_reset = 1'b1;
      tick;
      checks++;
      if (o_valid !== 1'b0 || o_fetch !== 1'b0 || o_pc !== 32'd0) begin
         failures++;
         $display("FAIL reset_in_issue: v=%b f=%b pc=%h, expected 0 0 00000000", o_valid, o_fetch, o_pc);
      end
      i_reset = 1'b0;
      #1;
      tick;
      // i_done coincident with reset is discarded.
      i_instruction = 48'h0000_0000_0000;
      i_done = 1'b1;
      i_reset = 1'b1;
      tick;
      i_done = 1'b0;
      i_reset = 1'b0;
      #1;
      checks++;
      if (o_fetch !== 1'b1 || o_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_drop_done: f=%b v=%b, expected 1 0", o_fetch, o_valid);
      end
      tick; tick; tick;
      checks++;
      if (o_valid !== 1'b0 || o_fetch !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_issue: v=%b f=%b, expected 0 0", o_valid, o_fetch);
      end
   endtask

   task automatic test_random;
      logic [47:0] ins;
      apply_reset;
      for (int t = 0; t < 40; t++) begin
         ins = {5'($urandom), 3'($urandom), 4'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), $urandom};
         do_instr(ins, 3'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom), {$urandom_range(0, 32'h7FFF_FFFF), 1'b0});
      end
      checks++;
      if (o_fetch !== 1'b1 || o_pc !== exp_pc) begin
         failures++;
         $display("FAIL random_end: f=%b pc=%h, expected 1 %h", o_fetch, o_pc, exp_pc);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      exp_pc = 32'd0;
      test_reset;
      test_basic;
      test_hold;
      test_cond;
      test_branch;
      test_illegal;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
